// File: rtl/input_debouncer.sv
// Per-channel 2-flop sync + stability counter; clean level and strobes move STABLE_CYCLES+2 edges after an input change.
// Latency fixed by STABLE_CYCLES; no backpressure, strobes are single-cycle and must be consumed when asserted.
module input_debouncer #(
    parameter int WIDTH         = 5,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] in_clean,
    output logic [WIDTH-1:0] in_rise,
    output logic [WIDTH-1:0] in_fall
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        SETTLING = 1'b1
    } ch_state_e;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    cnt [WIDTH];
    ch_state_e        ch_state [WIDTH];

    // State is implied by disagreement between the synchronised input and the clean level.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            ch_state[i] = (sync2[i] != in_clean[i]) ? SETTLING : IDLE;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            in_clean <= '0;
            in_rise  <= '0;
            in_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_raw;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                in_rise[i] <= 1'b0;
                in_fall[i] <= 1'b0;
                case (ch_state[i])
                    IDLE: cnt[i] <= '0;
                    SETTLING: begin
                        if (cnt[i] == CNT_MAX) begin
                            in_clean[i] <= sync2[i];
                            in_rise[i]  <= sync2[i];
                            in_fall[i]  <= ~sync2[i];
                            cnt[i]      <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: cnt[i] <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

    localparam int W  = 5;
    localparam int SC = 8;

    logic         clk_100mhz = 1'b0;
    logic         rst;
    logic [W-1:0] in_raw;
    logic [W-1:0] in_clean;
    logic [W-1:0] in_rise;
    logic [W-1:0] in_fall;

    int errors = 0;
    int checks = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    input_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
        .clk_100mhz(clk_100mhz),
        .rst       (rst),
        .in_raw    (in_raw),
        .in_clean  (in_clean),
        .in_rise   (in_rise),
        .in_fall   (in_fall)
    );

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        in_raw = 5'b11111;
        for (int n = 1; n <= 3; n++) begin
            tick();
            checks++;
            if ({in_clean, in_rise, in_fall} !== 15'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: clean=%b rise=%b fall=%b want all 0", n, in_clean, in_rise, in_fall);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            tick();
            checks++;
            if (in_clean !== ((n >= 10) ? 5'b11111 : 5'b00000) || in_rise !== ((n == 10) ? 5'b11111 : 5'b00000) || in_fall !== 5'b00000) begin
                errors++;
                $display("FAIL reset_release n=%0d: clean=%b rise=%b fall=%b", n, in_clean, in_rise, in_fall);
            end
        end
        in_raw = 5'b00000;
        for (int n = 1; n <= 11; n++) begin
            tick();
            checks++;
            if (in_clean !== ((n >= 10) ? 5'b00000 : 5'b11111) || in_fall !== ((n == 10) ? 5'b11111 : 5'b00000) || in_rise !== 5'b00000) begin
                errors++;
                $display("FAIL reset_return n=%0d: clean=%b rise=%b fall=%b", n, in_clean, in_rise, in_fall);
            end
        end
    endtask

    task automatic test_clean_step();
        in_raw[0] = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            tick();
            checks++;
            if (in_clean !== ((n >= 10) ? 5'b00001 : 5'b00000) || in_rise !== ((n == 10) ? 5'b00001 : 5'b00000) || in_fall !== 5'b00000) begin
                errors++;
                $display("FAIL clean_step n=%0d: clean=%b rise=%b fall=%b", n, in_clean, in_rise, in_fall);
            end
        end
    endtask

    task automatic test_glitch();
        // 7-cycle pulse is rejected; channel 0 stays high throughout.
        in_raw[1] = 1'b1;
        for (int n = 1; n <= 7; n++) tick();
        in_raw[1] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            checks++;
            if (in_clean !== 5'b00001 || in_rise !== 5'b00000 || in_fall !== 5'b00000) begin
                errors++;
                $display("FAIL glitch7 n=%0d: clean=%b rise=%b fall=%b want clean 00001", n, in_clean, in_rise, in_fall);
            end
        end
        in_raw[1] = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            if (n == 9) in_raw[1] = 1'b0;
            tick();
            checks++;
            if (in_clean !== ((n >= 10 && n <= 17) ? 5'b00011 : 5'b00001) || in_rise !== ((n == 10) ? 5'b00010 : 5'b00000) || in_fall !== ((n == 18) ? 5'b00010 : 5'b00000)) begin
                errors++;
                $display("FAIL glitch8 n=%0d: clean=%b rise=%b fall=%b", n, in_clean, in_rise, in_fall);
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] seq;
        seq = 6'b101101;
        for (int k = 5; k >= 1; k--) begin
            in_raw[2] = seq[k];
            tick();
            checks++;
            if (in_clean !== 5'b00001 || in_rise !== 5'b00000 || in_fall !== 5'b00000) begin
                errors++;
                $display("FAIL bounce_during k=%0d: clean=%b rise=%b fall=%b", k, in_clean, in_rise, in_fall);
            end
        end
        in_raw[2] = seq[0];
        for (int n = 1; n <= 11; n++) begin
            tick();
            checks++;
            if (in_clean !== ((n >= 10) ? 5'b00101 : 5'b00001) || in_rise !== ((n == 10) ? 5'b00100 : 5'b00000) || in_fall !== 5'b00000) begin
                errors++;
                $display("FAIL bounce_settle n=%0d: clean=%b rise=%b fall=%b", n, in_clean, in_rise, in_fall);
            end
        end
        in_raw = 5'b00000;
        for (int n = 1; n <= 11; n++) begin
            tick();
            checks++;
            if (in_clean !== ((n >= 10) ? 5'b00000 : 5'b00101) || in_fall !== ((n == 10) ? 5'b00101 : 5'b00000) || in_rise !== 5'b00000) begin
                errors++;
                $display("FAIL bounce_clear n=%0d: clean=%b rise=%b fall=%b", n, in_clean, in_rise, in_fall);
            end
        end
    endtask

    task automatic test_multi_channel();
        in_raw = 5'b10101;
        for (int n = 1; n <= 11; n++) begin
            tick();
            checks++;
            if (in_clean !== ((n >= 10) ? 5'b10101 : 5'b00000) || in_rise !== ((n == 10) ? 5'b10101 : 5'b00000) || in_fall !== 5'b00000) begin
                errors++;
                $display("FAIL multi_rise n=%0d: clean=%b rise=%b fall=%b", n, in_clean, in_rise, in_fall);
            end
        end
        in_raw = 5'b00000;
        for (int n = 1; n <= 11; n++) begin
            tick();
            checks++;
            if (in_clean !== ((n >= 10) ? 5'b00000 : 5'b10101) || in_fall !== ((n == 10) ? 5'b10101 : 5'b00000) || in_rise !== 5'b00000) begin
                errors++;
                $display("FAIL multi_fall n=%0d: clean=%b rise=%b fall=%b", n, in_clean, in_rise, in_fall);
            end
        end
    endtask

    task automatic test_reset_mid_settle();
        // Two sync edges plus five counting edges, then reset.
        in_raw[3] = 1'b1;
        for (int n = 1; n <= 7; n++) tick();
        rst = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            tick();
            checks++;
            if ({in_clean, in_rise, in_fall} !== 15'd0) begin
                errors++;
                $display("FAIL midsettle_rst n=%0d: clean=%b rise=%b fall=%b want all 0", n, in_clean, in_rise, in_fall);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            tick();
            checks++;
            if (in_clean !== ((n >= 10) ? 5'b01000 : 5'b00000) || in_rise !== ((n == 10) ? 5'b01000 : 5'b00000) || in_fall !== 5'b00000) begin
                errors++;
                $display("FAIL midsettle_release n=%0d: clean=%b rise=%b fall=%b", n, in_clean, in_rise, in_fall);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        in_raw = '0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_multi_channel();
        test_reset_mid_settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
